// File: rtl/key_pkg.sv
// Shared types and sizes for the 4x4 keypad column scanner.
package key_pkg;

   typedef enum logic [1:0] {SCAN, SETTLE_ST, CAPTURE, HOLD} scan_state_t;

   localparam int unsigned NUM_COLS  = 4;
   localparam int unsigned NUM_FILAS = 4;

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchroniser for asynchronous level inputs; resets to all ones (idle rows).
module sincronizador #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/key_barrido_columnas.sv
// 4x4 keypad column scanner: drives one active-low column at a time, freezes on a detect,
// locates the single low row and emits one code plus a one-cycle valid pulse per press.
module key_barrido_columnas
   import key_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 10_000,
   parameter int unsigned SETTLE   = 16
) (
   input  logic       clck_i,
   input  logic       rst_i,
   input  logic [3:0] filas_i,
   input  logic       deteccion_i,
   output logic [3:0] columnas_o,
   output logic [3:0] tecla_o,
   output logic       valida_o
);

   localparam int unsigned ColW = $clog2(NUM_COLS);
   localparam int unsigned DivW = $clog2(SCAN_DIV);
   localparam int unsigned SetW = $clog2(SETTLE);
   localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
   localparam logic [SetW-1:0] SetLast = SetW'(SETTLE - 1);

   function automatic logic [2:0] popcount(input logic [NUM_FILAS-1:0] v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < NUM_FILAS; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

   function automatic logic [1:0] fila_idx(input logic [NUM_FILAS-1:0] onehot);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_FILAS; i++) begin
         if (onehot[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   scan_state_t    state_q, state_d;
   logic [ColW-1:0] col_q, col_d;
   logic [DivW-1:0] div_q, div_d;
   logic [SetW-1:0] cnt_q, cnt_d;
   logic [1:0]      fila_q, fila_d;
   logic [3:0]      tecla_q, tecla_d;
   logic            valida_q, valida_d;

   logic [NUM_FILAS-1:0] filas_s;
   logic [NUM_FILAS-1:0] filas_low;

   sincronizador #(
      .WIDTH(NUM_FILAS)
   ) u_sync_filas (
      .clk_i (clck_i),
      .rst_ni(rst_i),
      .d_i   (filas_i),
      .q_o   (filas_s)
   );

   assign filas_low = ~filas_s;

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      div_d    = div_q;
      cnt_d    = cnt_q;
      fila_d   = fila_q;
      tecla_d  = tecla_q;
      valida_d = 1'b0;

      unique case (state_q)
         SCAN: begin
            // Detect takes priority so the column under the pressed key is not skipped.
            if (deteccion_i) begin
               state_d = SETTLE_ST;
               div_d   = '0;
               cnt_d   = '0;
            end else if (div_q == DivLast) begin
               div_d = '0;
               col_d = col_q + 1'b1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         SETTLE_ST: begin
            if (!deteccion_i) begin
               state_d = SCAN;
               col_d   = col_q + 1'b1;
               div_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == SetLast) begin
               cnt_d = '0;
               div_d = '0;
               if (popcount(filas_low) == 3'd1) begin
                  state_d = CAPTURE;
                  fila_d  = fila_idx(filas_low);
               end else begin
                  state_d = SCAN;
                  col_d   = col_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CAPTURE: begin
            tecla_d  = {fila_q, col_q};
            valida_d = 1'b1;
            state_d  = HOLD;
            cnt_d    = '0;
         end
         HOLD: begin
            // Any low row or a raised detect restarts the release window.
            if (!deteccion_i && (filas_s == 4'hF)) begin
               if (cnt_q == SetLast) begin
                  state_d = SCAN;
                  col_d   = col_q + 1'b1;
                  cnt_d   = '0;
                  div_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clck_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= SCAN;
         col_q    <= '0;
         div_q    <= '0;
         cnt_q    <= '0;
         fila_q   <= '0;
         tecla_q  <= 4'h0;
         valida_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         fila_q   <= fila_d;
         tecla_q  <= tecla_d;
         valida_q <= valida_d;
      end
   end

   assign columnas_o = ~(4'b0001 << col_q);
   assign tecla_o    = tecla_q;
   assign valida_o   = valida_q;

endmodule
